// File: rtl/gpio_input_debounce.sv
// gpio_input_debounce: input conditioning for the IO expander. It synchronizes the
// raw pads into wb_clk_i, debounces each bit on a shared prescaled tick, and drives
// the stable value together with a change strobe.
// Optional feature macro: GPIO_IRQ_EN enables the rise/fall pending flags and the
// irq output. Without it those outputs are tied to 0 and irq_mask/irq_clear are ignored.
module gpio_input_debounce #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE   = 16,
    parameter int STABLE_CNT = 3
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [WIDTH-1:0] io_in,
    input  logic             enable,
    input  logic [WIDTH-1:0] irq_mask,
    input  logic [WIDTH-1:0] irq_clear,
    output logic [WIDTH-1:0] io_out,
    output logic [WIDTH-1:0] io_oeb,
    output logic             in_valid,
    output logic [WIDTH-1:0] rise_pend,
    output logic [WIDTH-1:0] fall_pend,
    output logic             irq
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_CNT - 1);

    logic [WIDTH-1:0]         sync1_q, sync_q;
    logic [PW-1:0]            presc_q, presc_d;
    logic                     tick;
    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]         out_q, out_d;
    logic                     in_valid_q;
    logic [WIDTH-1:0]         oeb_q;

    // Two-flop synchronizer per pad bit, nothing between the stages.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours; blocking here would collapse the chain.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1_q <= '0;
            sync_q  <= '0;
        end else begin
            sync1_q <= io_in;
            sync_q  <= sync1_q;
        end
    end

    // Sample tick: last count of the prescaler while enabled.
    assign tick = enable && (presc_q == PRESC_LAST);

    // Prescaler next state: count while enabled, wrap after the tick, park at 0 when disabled.
    always_comb begin
        presc_d = '0;
        if (enable && !tick) begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Per-bit debounce: a bit must disagree with io_out on STABLE_CNT consecutive ticks.
    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (!enable) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (sync_q[i] == out_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    out_d[i] = sync_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Debounce state, registered outputs and the change strobe.
    // NOTE: the counter array is reset along with everything else, because a reset
    // in the middle of a debounce must throw away partial counts immediately.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            presc_q    <= '0;
            cnt_q      <= '0;
            out_q      <= '0;
            in_valid_q <= 1'b0;
            oeb_q      <= '1;
        end else begin
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            in_valid_q <= (out_d != out_q);
            oeb_q      <= ~{WIDTH{enable}};
        end
    end

    assign io_out   = out_q;
    assign io_oeb   = oeb_q;
    assign in_valid = in_valid_q;

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;
    logic             irq_q;

    // Sticky edge flags: a set in the same cycle as a clear wins.
    always_comb begin
        rise_d = (rise_q & ~irq_clear) | (out_d & ~out_q);
        fall_d = (fall_q & ~irq_clear) | (~out_d & out_q);
    end

    // Flag registers and the interrupt, which lags the flags by one cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rise_q <= '0;
            fall_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
            irq_q  <= |((rise_q | fall_q) & irq_mask);
        end
    end

    assign rise_pend = rise_q;
    assign fall_pend = fall_q;
    assign irq       = irq_q;
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = ^{irq_mask, irq_clear};

    assign rise_pend = '0;
    assign fall_pend = '0;
    assign irq       = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_input_debounce.sv
// Directed bench for gpio_input_debounce with PRESCALE=4, STABLE_CNT=3.
// Expected io_out/flag values are queued when the pads are driven and compared
// whenever the DUT pulses in_valid. Flag expectations follow GPIO_IRQ_EN.
module tb_gpio_input_debounce;

`ifdef GPIO_IRQ_EN
    localparam logic [7:0] FLAG_MASK = 8'hFF;
    localparam logic       IRQ_EN    = 1'b1;
`else
    localparam logic [7:0] FLAG_MASK = 8'h00;
    localparam logic       IRQ_EN    = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] io_in = '0;
    logic       enable = 1'b0;
    logic [7:0] irq_mask = '0;
    logic [7:0] irq_clear = '0;
    logic [7:0] io_out, io_oeb, rise_pend, fall_pend;
    logic       in_valid, irq;

    typedef struct packed {
        logic [7:0] out;
        logic [7:0] rise;
        logic [7:0] fall;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    gpio_input_debounce #(
        .WIDTH(8),
        .PRESCALE(4),
        .STABLE_CNT(3)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .io_in    (io_in),
        .enable   (enable),
        .irq_mask (irq_mask),
        .irq_clear(irq_clear),
        .io_out   (io_out),
        .io_oeb   (io_oeb),
        .in_valid (in_valid),
        .rise_pend(rise_pend),
        .fall_pend(fall_pend),
        .irq      (irq)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fm(input logic [7:0] x);
        return x & FLAG_MASK;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Poll io_out once per cycle until it reaches target; check the latency window.
    task automatic wait_out(input string tag, input logic [7:0] target, input int lo, input int hi);
        int  lat;
        bit  hit;
        lat = 0;
        hit = 1'b0;
        while (!hit && lat < hi + 5) begin
            @(negedge clk);
            lat++;
            if (io_out === target) hit = 1'b1;
        end
        if (hit) check({tag, "_latency_in_window"}, 8'(lat >= lo && lat <= hi), 8'd1);
        else     check({tag, "_reached"}, io_out, target);
    endtask

    // Scoreboard side: every in_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && in_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_in_valid", 8'(in_valid), 8'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_io_out", io_out, mon_e.out);
                check("sb_rise_pend", rise_pend, mon_e.rise);
                check("sb_fall_pend", fall_pend, mon_e.fall);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held while pads toggle.
        rst    = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            io_in = 8'(i * 37 + 5);
            @(negedge clk);
            check("rst_io_out", io_out, 8'h00);
            check("rst_io_oeb", io_oeb, 8'hFF);
            check("rst_irq", 8'(irq), 8'h00);
        end
        check("rst_rise_pend", rise_pend, 8'h00);
        check("rst_in_valid", 8'(in_valid), 8'h00);
        io_in = 8'h00;
        step(2);
        rst = 1'b0;
        step(6);
        check("oeb_enabled", io_oeb, 8'h00);
        check("idle_io_out", io_out, 8'h00);

        // Pattern pass-through.
        sb_q.push_back('{8'hAA, fm(8'hAA), 8'h00});
        io_in = 8'hAA;
        wait_out("pass", 8'hAA, 11, 15);
        step(20);
        check("pass_rise_pend", rise_pend, fm(8'hAA));
        check("pass_fall_pend", fall_pend, 8'h00);
        check("pass_irq_masked", 8'(irq), 8'h00);
        check("pass_sb_drained", 8'(sb_q.size()), 8'd0);

        // Glitch rejection: bit 0 high for 6 cycles.
        io_in = 8'hAB;
        step(6);
        io_in = 8'hAA;
        step(20);
        check("glitch_io_out", io_out, 8'hAA);
        check("glitch_rise_pend", rise_pend, fm(8'hAA));

        // Clear all flags, then unmask bit 1.
        irq_clear = 8'hFF;
        step(1);
        irq_clear = 8'h00;
        check("clear_all_rise", rise_pend, 8'h00);
        check("clear_all_fall", fall_pend, 8'h00);
        irq_mask = 8'h02;
        step(3);
        check("mask_no_irq", 8'(irq), 8'h00);

        // Falling edge on bit 1 raises irq one cycle after the flag.
        sb_q.push_back('{8'hA8, 8'h00, fm(8'h02)});
        io_in = 8'hA8;
        wait_out("fall", 8'hA8, 11, 15);
        check("fall_pend_set", fall_pend, fm(8'h02));
        check("fall_irq_not_yet", 8'(irq), 8'h00);
        step(1);
        check("fall_irq_set", 8'(irq), 8'(IRQ_EN));

        // Write-1-to-clear; irq drops one cycle after the flag.
        irq_clear = 8'h02;
        step(1);
        irq_clear = 8'h00;
        check("clear_fall_pend", fall_pend, 8'h00);
        check("clear_irq_lag", 8'(irq), 8'(IRQ_EN));
        step(1);
        check("clear_irq_low", 8'(irq), 8'h00);

        // Set and clear in the same cycle: set wins.
        irq_clear = 8'h02;
        sb_q.push_back('{8'hAA, fm(8'h02), 8'h00});
        io_in = 8'hAA;
        wait_out("setwins", 8'hAA, 11, 15);
        check("setwins_rise_pend", rise_pend, fm(8'h02));
        irq_clear = 8'h00;
        step(1);
        check("setwins_rise_held", rise_pend, fm(8'h02));
        check("setwins_irq", 8'(irq), 8'(IRQ_EN));

        // Enable gating.
        check("gate_oeb_before", io_oeb, 8'h00);
        enable = 1'b0;
        io_in  = 8'h55;
        step(1);
        check("gate_oeb_off", io_oeb, 8'hFF);
        irq_clear = 8'h02;
        step(1);
        irq_clear = 8'h00;
        check("gate_clear_works", rise_pend, 8'h00);
        step(30);
        check("gate_io_out_held", io_out, 8'hAA);
        check("gate_irq_low", 8'(irq), 8'h00);
        sb_q.push_back('{8'h55, fm(8'h55), fm(8'hAA)});
        enable = 1'b1;
        wait_out("reenable", 8'h55, 11, 15);
        step(1);
        check("reenable_irq", 8'(irq), 8'(IRQ_EN));
        check("reenable_oeb", io_oeb, 8'h00);

        // Reset in the middle of a debounce (two qualifying ticks in).
        io_in = 8'h0F;
        step(10);
        check("mid_no_update", io_out, 8'h55);
        #2 rst = 1'b1;
        #1;
        check("async_rst_io_out", io_out, 8'h00);
        check("async_rst_io_oeb", io_oeb, 8'hFF);
        check("async_rst_rise", rise_pend, 8'h00);
        check("async_rst_fall", fall_pend, 8'h00);
        check("async_rst_irq", 8'(irq), 8'h00);
        @(negedge clk);
        rst = 1'b0;
        sb_q.push_back('{8'h0F, fm(8'h0F), 8'h00});
        wait_out("post_reset", 8'h0F, 11, 15);
        step(10);
        check("final_sb_drained", 8'(sb_q.size()), 8'd0);
        check("final_irq", 8'(irq), 8'(IRQ_EN));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpio_input_debounce.md
# gpio_input_debounce

Input conditioning stage of the user-project IO expander. It samples the raw GPIO input pads (mprj_io[31:24]) and synchronizes them into the wb_clk_i domain. It debounces each bit with a shared sample tick and drives the stable value to the output stage that mirrors it onto mprj_io[23:16]. It also records rising and falling edges as maskable pending flags and raises one interrupt line to the management core.

## Interface
Parameters:
- WIDTH, 8, number of input bits handled.
- PRESCALE, 16, wb_clk_i cycles per sample tick (≥2).
- STABLE_CNT, 3, consecutive differing ticks required to accept a new level (≥1).

Ports:
- wb_clk_i  in  1  the block's only clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- io_in  in  WIDTH  raw pad inputs; asynchronous to wb_clk_i.
- enable  in  1  block enable.
- irq_mask  in  WIDTH  1 = bit contributes to irq.
- irq_clear  in  WIDTH  one-cycle write-1-to-clear strobe for pending flags.
- io_out  out  WIDTH  debounced input value, registered.
- io_oeb  out  WIDTH  active-low output enable for the mirrored pads, registered.
- in_valid  out  1  one-cycle pulse when io_out changes.
- rise_pend  out  WIDTH  sticky rising-edge flags.
- fall_pend  out  WIDTH  sticky falling-edge flags.
- irq  out  1  registered interrupt.

## Operation
- Synchronizer: two flops per bit, io_in → sync1 → sync. No logic between the stages.
- Prescaler: counter 0..PRESCALE-1. It increments while enable=1 and wraps to 0. tick=1 for one cycle when the counter equals PRESCALE-1. With enable=0 the counter is held at 0.
- Per-bit debounce counter, width $clog2(STABLE_CNT+1). On tick:
  - If sync[i]==io_out[i], the counter clears.
  - Otherwise, if counter==STABLE_CNT-1, io_out[i] takes sync[i] and the counter clears.
  - Otherwise, the counter increments.
  - Between ticks the counters hold.
- A glitch shorter than one tick interval is rejected. A level that reverts before STABLE_CNT ticks resets the count.
- in_valid pulses on the cycle io_out changes. When several bits change together, one pulse is produced.
- Edge flags:
  - rise_pend[i] sets on an io_out[i] 0→1 update.
  - fall_pend[i] sets on an io_out[i] 1→0 update.
  - irq_clear[i] clears both flags for bit i.
  - If a set and a clear occur in the same cycle, the set wins.
- irq is registered: irq = |((rise_pend|fall_pend) & irq_mask), one cycle after the flags.
- io_oeb is registered: io_oeb = ~{WIDTH{enable}}.
- enable=0 behaviour:
  - Debounce counters clear; io_out and pending flags hold.
  - irq_clear still operates.
- Reset values: io_out=0, io_oeb=all 1s, in_valid=0, rise_pend=0, fall_pend=0, irq=0. Synchronizer, prescaler and debounce counters are all 0.
- Reset asserted mid-debounce discards all partial counts immediately. Reset does not generate edge flags.

## Timing
- Synchronizer latency: 2 cycles from a pad change to sync.
- io_out updates on the cycle after the STABLE_CNT-th qualifying tick.
- Total latency from a stable pad change to io_out:
  - minimum 2 + (STABLE_CNT-1)·PRESCALE + 1 cycles;
  - maximum 2 + STABLE_CNT·PRESCALE + 1 cycles.
- rise_pend, fall_pend and in_valid change in the same cycle as io_out. irq follows one cycle later.
- io_oeb follows enable with 1 cycle of latency.
- After reset deassertion the first tick occurs PRESCALE cycles after enable is sampled high.

## Configuration
- GPIO_IRQ_EN defined: edge flags, irq_mask/irq_clear handling and irq are implemented as described.
- GPIO_IRQ_EN undefined:
  - rise_pend, fall_pend and irq are tied to 0.
  - irq_mask and irq_clear are ignored.
  - No flag registers are synthesized.
  - Debounce, io_out, io_oeb and in_valid are unchanged.

## Test plan
Bench parameters: PRESCALE=4, STABLE_CNT=3, GPIO_IRQ_EN defined.
- Reset: hold wb_rst_i, toggle io_in → io_out=0x00, io_oeb=0xFF, irq=0 throughout; asynchronous assertion mid-cycle clears the outputs immediately.
- Pattern pass-through: enable=1, io_in=0xAA held → io_out=0xAA within 11..15 cycles; one in_valid pulse; rise_pend=0xAA; fall_pend=0x00.
- Glitch rejection: from 0xAA, bit 0 high for 6 cycles then back low → io_out stays 0xAA, no in_valid, rise_pend unchanged.
- Interrupt and clear:
  - irq_mask=0x02, io_in 0xAA→0xA8 → fall_pend=0x02, irq=1 one cycle later.
  - irq_clear=0x02 → fall_pend=0x00, irq=0 next cycle.
  - A same-cycle set and clear leaves the flag at 1.
- Enable gating: enable=0, io_in changes to 0x55 → io_out holds 0xAA, io_oeb=0xFF after 1 cycle. Re-enable → io_out=0x55 within 15 cycles.
- Reset mid-debounce: pulse wb_rst_i after 2 qualifying ticks → counts cleared; after release, the full STABLE_CNT ticks are needed again before io_out updates.
